// File: rtl/cw_sequencer.sv
// cw_sequencer: fetches instructions, steps the CU state through execute cycles, owns IR/state/NZCV.
// Phase changes take one clock; mem_ready low stalls FETCH and IR_load execute cycles indefinitely.
module cw_sequencer #(
   parameter int CUL      = 36,
   parameter int MAX_EXEC = 8
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [31:0]    mem_data,
   input  logic           mem_ready,
   input  logic [3:0]     NS,
   input  logic [CUL:0]   controlWord,
   input  logic [3:0]     status_in,
   output logic [31:0]    IR,
   output logic [3:0]     state,
   output logic [3:0]     status,
   output logic           mem_req,
   output logic           rf_we,
   output logic           mem_we,
   output logic           pc_step,
   output logic [1:0]     pc_fs,
   output logic           abort
);

   typedef struct packed {
      logic       spare;
      logic [4:0] fs;
      logic [4:0] sa;
      logic [4:0] sb;
      logic [4:0] da;
      logic       w_reg;
      logic       c0;
      logic [1:0] mem_cs;
      logic       b_sel;
      logic       mem_write_en;
      logic       ir_load;
      logic       status_load;
      logic [1:0] size;
      logic       add_tri_sel;
      logic [1:0] data_tri_sel;
      logic       pc_sel;
      logic [1:0] pc_fs;
   } cw_t;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_FETCH = 2'd1,
      PH_EXEC  = 2'd2
   } phase_t;

   localparam int               CNT_W    = $clog2(MAX_EXEC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_EXEC - 1);
   localparam logic [1:0]       PC_INC   = 2'b01;

   cw_t              cw;
   phase_t           phase_q, phase_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   logic [31:0]      ir_nx;
   logic [3:0]       state_nx, status_nx;
   logic [1:0]       pc_fs_nx;
   logic             mem_req_nx, pc_step_nx, abort_nx;
   logic             in_exec, stall;
   logic             unused_cw;

   assign cw = cw_t'(controlWord[36:0]);

   // Datapath fields are consumed elsewhere; only the sequencing fields matter here.
   assign unused_cw = ^{cw.spare, cw.fs, cw.sa, cw.sb, cw.da, cw.c0, cw.mem_cs, cw.b_sel,
                        cw.size, cw.add_tri_sel, cw.data_tri_sel, cw.pc_sel};

   assign in_exec = (phase_q == PH_EXEC);
   assign stall   = in_exec & cw.ir_load & ~mem_ready;

   // Strobes are combinational so they line up with the control word of the current state.
   assign rf_we  = reset_n & in_exec & ~stall & cw.w_reg;
   assign mem_we = reset_n & in_exec & ~stall & cw.mem_write_en;

   always_comb begin
      phase_nx   = phase_q;
      cnt_nx     = cnt_q;
      ir_nx      = IR;
      state_nx   = state;
      status_nx  = status;
      pc_fs_nx   = pc_fs;
      pc_step_nx = 1'b0;
      abort_nx   = 1'b0;
      mem_req_nx = 1'b0;

      case (phase_q)
         PH_IDLE: begin
            phase_nx = PH_FETCH;
         end
         PH_FETCH: begin
            if (mem_ready) begin
               ir_nx    = mem_data;
               state_nx = 4'd0;
               cnt_nx   = '0;
               phase_nx = PH_EXEC;
            end
         end
         PH_EXEC: begin
            if (!stall) begin
               if (cw.ir_load) begin
                  ir_nx = mem_data;
               end
               if (cw.status_load) begin
                  status_nx = status_in;
               end
               if (NS == 4'd0) begin
                  phase_nx   = PH_FETCH;
                  state_nx   = 4'd0;
                  cnt_nx     = '0;
                  pc_step_nx = 1'b1;
                  pc_fs_nx   = cw.pc_fs;
               end else if (cnt_q == CNT_LAST) begin
                  // Runaway instruction: give up and move on to the next one.
                  phase_nx   = PH_FETCH;
                  state_nx   = 4'd0;
                  cnt_nx     = '0;
                  pc_step_nx = 1'b1;
                  pc_fs_nx   = PC_INC;
                  abort_nx   = 1'b1;
               end else begin
                  state_nx = NS;
                  cnt_nx   = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            phase_nx = PH_IDLE;
         end
      endcase

      mem_req_nx = (phase_nx == PH_FETCH);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= PH_IDLE;
         cnt_q   <= '0;
         IR      <= 32'd0;
         state   <= 4'd0;
         status  <= 4'd0;
         mem_req <= 1'b0;
         pc_step <= 1'b0;
         pc_fs   <= 2'b00;
         abort   <= 1'b0;
      end else begin
         phase_q <= phase_nx;
         cnt_q   <= cnt_nx;
         IR      <= ir_nx;
         state   <= state_nx;
         status  <= status_nx;
         mem_req <= mem_req_nx;
         pc_step <= pc_step_nx;
         pc_fs   <= pc_fs_nx;
         abort   <= abort_nx;
      end
   end

endmodule

// File: tb/tb_cw_sequencer.sv
// Bench for cw_sequencer: directed instruction sequences, retirements scored against a queue of expected records.
module tb_cw_sequencer;

   logic        clock;
   logic        reset_n;
   logic [31:0] mem_data;
   logic        mem_ready;
   logic [3:0]  NS;
   logic [36:0] controlWord;
   logic [3:0]  status_in;
   logic [31:0] IR;
   logic [3:0]  state;
   logic [3:0]  status;
   logic        mem_req;
   logic        rf_we;
   logic        mem_we;
   logic        pc_step;
   logic [1:0]  pc_fs;
   logic        abort;

   typedef struct packed {
      logic [1:0]  pc_fs;
      logic        abort;
      logic [31:0] ir;
      logic [3:0]  status;
   } ret_t;

   ret_t sb[$];
   ret_t mon_r;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [3:0] exp_status;

   cw_sequencer #(.CUL(36), .MAX_EXEC(8)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .mem_data    (mem_data),
      .mem_ready   (mem_ready),
      .NS          (NS),
      .controlWord (controlWord),
      .status_in   (status_in),
      .IR          (IR),
      .state       (state),
      .status      (status),
      .mem_req     (mem_req),
      .rf_we       (rf_we),
      .mem_we      (mem_we),
      .pc_step     (pc_step),
      .pc_fs       (pc_fs),
      .abort       (abort)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   // Random filler in the datapath fields proves the sequencer ignores them.
   function automatic logic [36:0] mk_cw(input logic w, input logic mw, input logic irl,
                                         input logic sl, input logic [1:0] pcfs);
      logic [36:0] c;
      c[31:0]  = $urandom;
      c[36:32] = 5'($urandom);
      c[15]    = w;
      c[10]    = mw;
      c[9]     = irl;
      c[8]     = sl;
      c[1:0]   = pcfs;
      return c;
   endfunction

   task automatic push_ret(input logic [1:0] fs, input logic ab, input logic [31:0] ir,
                           input logic [3:0] st);
      ret_t r;
      r.pc_fs  = fs;
      r.abort  = ab;
      r.ir     = ir;
      r.status = st;
      sb.push_back(r);
   endtask

   task automatic fetch(input logic [31:0] d);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         mem_ready   = 1'b1;
         mem_data    = d;
         NS          = 4'd0;
         controlWord = mk_cw(1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
         #1;
         n++;
      end while (mem_req !== 1'b1 && n < 20);
      check_eq("fetch_req", 64'(mem_req), 64'(1));
      check_eq("fetch_we_gated", 64'({rf_we, mem_we}), 64'(0));
   endtask

   task automatic exec(input logic [3:0] ns, input logic w, input logic mw, input logic irl,
                       input logic sl, input logic [1:0] pcfs, input logic rdy,
                       input logic [31:0] d, input logic [3:0] sin,
                       input logic [3:0] exp_state, input logic [31:0] exp_ir);
      logic [1:0] exp_we;
      @(negedge clock);
      NS          = ns;
      controlWord = mk_cw(w, mw, irl, sl, pcfs);
      mem_ready   = rdy;
      mem_data    = d;
      status_in   = sin;
      #1;
      exp_we = (irl && !rdy) ? 2'b00 : {w, mw};
      check_eq("exec_state", 64'(state), 64'(exp_state));
      check_eq("exec_ir", 64'(IR), 64'(exp_ir));
      check_eq("exec_we", 64'({rf_we, mem_we}), 64'(exp_we));
      check_eq("exec_quiet", 64'({mem_req, pc_step, abort}), 64'(0));
   endtask

   task automatic post_retire(input logic [1:0] exp_fs, input logic exp_abort);
      @(negedge clock);
      mem_ready   = 1'b0;
      NS          = 4'd0;
      controlWord = mk_cw(1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
      #1;
      check_eq("retire_step", 64'(pc_step), 64'(1));
      check_eq("retire_fs", 64'(pc_fs), 64'(exp_fs));
      check_eq("retire_abort", 64'(abort), 64'(exp_abort));
      check_eq("retire_req", 64'(mem_req), 64'(1));
      check_eq("retire_we_gated", 64'({rf_we, mem_we}), 64'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq(tag, 64'({IR, state, status, mem_req, rf_we, mem_we, pc_step, pc_fs, abort}), 64'(0));
   endtask

   // Each pc_step retires exactly one expected record.
   always @(negedge clock) begin
      #2;
      if (reset_n === 1'b1 && pc_step === 1'b1) begin
         if (sb.size() == 0) begin
            check_eq("sb_extra_step", 64'(pc_step), 64'(0));
         end else begin
            mon_r = sb.pop_front();
            check_eq("sb_pc_fs", 64'(pc_fs), 64'(mon_r.pc_fs));
            check_eq("sb_abort", 64'(abort), 64'(mon_r.abort));
            check_eq("sb_ir", 64'(IR), 64'(mon_r.ir));
            check_eq("sb_status", 64'(status), 64'(mon_r.status));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1);
   end

   initial begin
      reset_n     = 1'b0;
      mem_data    = 32'd0;
      mem_ready   = 1'b0;
      NS          = 4'd0;
      status_in   = 4'd0;
      controlWord = mk_cw(1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
      exp_status  = 4'd0;
      #3;
      check_all_zero("reset_outputs");

      // Release into IDLE, then FETCH one clock later.
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1;
      check_all_zero("idle_outputs");
      @(negedge clock);
      #1;
      check_eq("first_fetch_req", 64'(mem_req), 64'(1));
      check_eq("first_fetch_we", 64'({rf_we, mem_we, pc_step, abort}), 64'(0));

      // ADD X3,X1,X2: single EXEC cycle writing the register file.
      push_ret(2'b01, 1'b0, 32'h8B020023, exp_status);
      fetch(32'h8B020023);
      exec(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, $urandom, 4'hF, 4'd0, 32'h8B020023);
      post_retire(2'b01, 1'b0);

      // SUBS loads flags; the next instruction leaves them alone.
      exp_status = 4'b0110;
      push_ret(2'b01, 1'b0, 32'hEB020023, exp_status);
      fetch(32'hEB020023);
      exec(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, $urandom, 4'b0110, 4'd0, 32'hEB020023);
      post_retire(2'b01, 1'b0);
      check_eq("status_loaded", 64'(status), 64'(4'b0110));

      push_ret(2'b10, 1'b0, 32'h8B030024, exp_status);
      fetch(32'h8B030024);
      exec(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, $urandom, 4'b1111, 4'd0, 32'h8B030024);
      post_retire(2'b10, 1'b0);
      check_eq("status_held", 64'(status), 64'(4'b0110));

      // Multi-state instruction walking NS 3,5,0.
      push_ret(2'b11, 1'b0, 32'hF8000041, exp_status);
      fetch(32'hF8000041);
      exec(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, $urandom, 4'hF, 4'd0, 32'hF8000041);
      exec(4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, $urandom, 4'hF, 4'd3, 32'hF8000041);
      exec(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, $urandom, 4'hF, 4'd5, 32'hF8000041);
      post_retire(2'b11, 1'b0);

      // IR_load stalls while memory is not ready, then loads and advances.
      push_ret(2'b00, 1'b0, 32'hCAFE0002, exp_status);
      fetch(32'hAAAA0001);
      exec(4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'hCAFE0002, 4'hF, 4'd0, 32'hAAAA0001);
      exec(4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'hCAFE0002, 4'hF, 4'd0, 32'hAAAA0001);
      exec(4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'hCAFE0002, 4'hF, 4'd0, 32'hAAAA0001);
      exec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, $urandom, 4'hF, 4'd2, 32'hCAFE0002);
      post_retire(2'b00, 1'b0);

      // NS stuck non-zero: watchdog fires after the 8th EXEC cycle with a forced increment.
      push_ret(2'b01, 1'b1, 32'h12345678, exp_status);
      fetch(32'h12345678);
      for (int k = 0; k < 8; k++) begin
         exec(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, $urandom, 4'hF,
              (k == 0) ? 4'd0 : 4'd1, 32'h12345678);
      end
      post_retire(2'b01, 1'b1);
      @(negedge clock);
      #1;
      check_eq("abort_one_cycle", 64'({abort, pc_step}), 64'(0));

      // Reset in the middle of EXEC clears everything immediately, no retirement.
      fetch(32'h0BADF00D);
      exec(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, $urandom, 4'hF, 4'd0, 32'h0BADF00D);
      @(negedge clock);
      NS          = 4'd0;
      controlWord = mk_cw(1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
      status_in   = 4'hF;
      reset_n     = 1'b0;
      #1;
      check_all_zero("midexec_reset");
      exp_status = 4'd0;
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check_all_zero("midexec_reset_idle");

      // mem_ready in FETCH coinciding with reset assertion: reset wins.
      fetch(32'hDEADBEEF);
      @(posedge clock);
      reset_n = 1'b0;
      #1;
      check_eq("fetch_reset_ir", 64'(IR), 64'(0));
      @(negedge clock);
      mem_ready = 1'b0;
      reset_n   = 1'b1;

      // Recovery: a normal instruction after reset.
      push_ret(2'b01, 1'b0, 32'h8B010001, exp_status);
      fetch(32'h8B010001);
      exec(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, $urandom, 4'hF, 4'd0, 32'h8B010001);
      post_retire(2'b01, 1'b0);

      repeat (3) @(negedge clock);
      #3;
      check_eq("sb_drained", 64'(sb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
